// File: rtl/weight_stream_tx_pkg.sv
// Shared definitions for the weight stream transmitter: FSM encoding and
// the legal READ_LATENCY range.
package weight_stream_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;

   function automatic bit read_latency_ok(input int rl);
      return (rl >= READ_LATENCY_MIN) && (rl <= READ_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/weight_stream_tx_if.sv
// Memory read port plus outgoing weight stream of one transmitter.
interface weight_stream_tx_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20
);
   // Both sides are valid-only: mem_rd_data is trusted exactly READ_LATENCY
   // cycles after mem_rd_en, and weight_out is consumed on every cycle that
   // valid_weight_out is high. There is no ready and no backpressure.
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  valid_weight_out;
   logic [DATA_WIDTH-1:0] weight_out;

   modport master (
      output mem_rd_en,
      output mem_addr,
      input  mem_rd_data,
      output valid_weight_out,
      output weight_out
   );

   modport slave (
      input  mem_rd_en,
      input  mem_addr,
      output mem_rd_data,
      input  valid_weight_out,
      input  weight_out
   );
endinterface

// File: rtl/weight_stream_tx_valid_delay_line.sv
// Shift register that tracks read strobes until their data returns; any_o
// reports whether any read is still in flight.
module weight_stream_tx_valid_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic strobe_i,
   output logic strobe_o,
   output logic any_o
);

   logic [DEPTH-1:0] stage_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q[0] <= strobe_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign strobe_o = stage_q[DEPTH-1];
   assign any_o    = |stage_q;

endmodule

// File: rtl/weight_stream_tx.sv
// Streams a contiguous block of weights from a synchronous memory to one conv
// weight port, one word per cycle, throttled only by pause.
module weight_stream_tx
   import weight_stream_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 20,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-1:0] num_words,
   input  logic                  pause,
   output logic                  busy,
   output logic                  done,
   output state_t                state_dbg_o,
   weight_stream_tx_if.master    tx
);

   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
      $error("weight_stream_tx: READ_LATENCY must be within 1..4");
   end

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] remaining_q;
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] weight_q;
   logic                  issue;
   logic                  data_strobe;
   logic                  in_flight;

   assign issue = (state_q == ST_ISSUE) && !pause;

   weight_stream_tx_valid_delay_line #(
      .DEPTH (READ_LATENCY)
   ) u_valid_delay (
      .clk      (clk),
      .reset    (reset),
      .strobe_i (issue),
      .strobe_o (data_strobe),
      .any_o    (in_flight)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  addr_q      <= base_addr;
                  remaining_q <= num_words;
                  state_q     <= (num_words == '0) ? ST_FIN : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (!pause) begin
                  // Address wraps naturally at 2^ADDR_WIDTH.
                  addr_q      <= addr_q + ADDR_WIDTH'(1);
                  remaining_q <= remaining_q - ADDR_WIDTH'(1);
                  if (remaining_q == ADDR_WIDTH'(1)) begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!in_flight) begin
                  state_q <= ST_FIN;
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Output word register holds its value between valid beats.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q  <= 1'b0;
         weight_q <= '0;
      end else begin
         valid_q <= data_strobe;
         if (data_strobe) begin
            weight_q <= tx.mem_rd_data;
         end
      end
   end

   assign tx.mem_rd_en        = issue;
   assign tx.mem_addr         = addr_q;
   assign tx.valid_weight_out = valid_q;
   assign tx.weight_out       = weight_q;
   assign busy                = (state_q != ST_IDLE);
   assign done                = (state_q == ST_FIN);
   assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_weight_stream_tx.sv
// Directed bench for weight_stream_tx: one READ_LATENCY=1 and one
// READ_LATENCY=3 instance, each fed by a memory returning word[a] = a.
module tb_weight_stream_tx;
   import weight_stream_tx_pkg::*;

   localparam int DW = 32;
   localparam int AW = 20;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic          start1, pause1, busy1, done1;
   logic [AW-1:0] base1, num1;
   state_t        st1;
   logic          start3, pause3, busy3, done3;
   logic [AW-1:0] base3, num3;
   state_t        st3;

   weight_stream_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
   weight_stream_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if3 ();

   weight_stream_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start1), .base_addr(base1), .num_words(num1),
      .pause(pause1), .busy(busy1), .done(done1), .state_dbg_o(st1), .tx(if1)
   );

   weight_stream_tx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3), .base_addr(base3), .num_words(num3),
      .pause(pause3), .busy(busy3), .done(done3), .state_dbg_o(st3), .tx(if3)
   );

   // Memory models; non-read cycles return a marker so misaligned capture shows.
   logic [DW-1:0] m1_q;
   logic [DW-1:0] m3_q [3];
   always @(posedge clk) begin
      m1_q    <= if1.mem_rd_en ? {12'h0, if1.mem_addr} : 32'hDEAD_BEEF;
      m3_q[0] <= if3.mem_rd_en ? {12'h0, if3.mem_addr} : 32'hDEAD_BEEF;
      m3_q[1] <= m3_q[0];
      m3_q[2] <= m3_q[1];
   end
   assign if1.mem_rd_data = m1_q;
   assign if3.mem_rd_data = m3_q[2];

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int n_done1  = 0;
   logic [DW-1:0] got_q[$];
   logic [DW-1:0] exp_q[$];

   always @(negedge clk) begin
      if (if1.valid_weight_out) got_q.push_back(if1.weight_out);
      if (done1) n_done1++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk_stream(input string tag, input int exp_done);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({tag, "_word"}, got_q[i], exp_q[i]);
      chk({tag, "_done_count"}, n_done1, exp_done);
      got_q.delete();
      exp_q.delete();
      n_done1 = 0;
   endtask

   task automatic chk_quiet1(input string tag);
      chk({tag, "_rd_en"}, if1.mem_rd_en, 0);
      chk({tag, "_addr"}, if1.mem_addr, 0);
      chk({tag, "_valid"}, if1.valid_weight_out, 0);
      chk({tag, "_weight"}, if1.weight_out, 0);
      chk({tag, "_busy"}, busy1, 0);
      chk({tag, "_done"}, done1, 0);
      chk({tag, "_state"}, st1, ST_IDLE);
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [AW-1:0] wrap_a [4];

   initial begin
      wrap_a = '{20'hFFFFE, 20'hFFFFF, 20'h00000, 20'h00001};
      reset = 1'b0;
      start1 = 0; pause1 = 0; base1 = '0; num1 = '0;
      start3 = 0; pause3 = 0; base3 = '0; num3 = '0;

      // Reset state
      repeat (3) step();
      chk_quiet1("reset");
      chk("reset_rd_en3", if3.mem_rd_en, 0);
      chk("reset_valid3", if3.valid_weight_out, 0);
      chk("reset_busy3", busy3, 0);
      reset = 1'b1;
      step();
      got_q.delete(); n_done1 = 0;

      // Basic stream, base 0x10, 4 words
      base1 = 20'h10; num1 = 20'd4; start1 = 1;
      for (int c = 1; c <= 8; c++) begin
         step(); start1 = 0; settle(); cyc = c;
         chk("basic_rd_en", if1.mem_rd_en, (c >= 1 && c <= 4));
         if (c >= 1 && c <= 4) chk("basic_addr", if1.mem_addr, 32'h10 + c - 1);
         chk("basic_valid", if1.valid_weight_out, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) chk("basic_weight", if1.weight_out, 32'h10 + c - 3);
         chk("basic_done", done1, (c == 7));
         chk("basic_busy", busy1, (c <= 7));
      end
      exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
      chk_stream("basic", 1);

      // Zero length
      base1 = 20'h55; num1 = 20'd0; start1 = 1;
      step(); start1 = 0; settle(); cyc = 1;
      chk("zero_busy", busy1, 1);
      chk("zero_done", done1, 1);
      chk("zero_rd_en", if1.mem_rd_en, 0);
      step(); settle(); cyc = 2;
      chk("zero_busy_after", busy1, 0);
      chk("zero_done_after", done1, 0);
      step();
      chk_stream("zero", 1);

      // Pause for 3 cycles after the 2nd read
      base1 = 20'h40; num1 = 20'd6; start1 = 1;
      for (int c = 1; c <= 13; c++) begin
         step(); start1 = 0; pause1 = (c >= 3 && c <= 5); settle(); cyc = c;
         chk("pause_rd_en", if1.mem_rd_en, (c inside {1, 2, 6, 7, 8, 9}));
         chk("pause_valid", if1.valid_weight_out, (c inside {3, 4, 8, 9, 10, 11}));
         chk("pause_done", done1, (c == 12));
      end
      pause1 = 0;
      exp_q = '{32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45};
      chk_stream("pause", 1);

      // Address wrap with READ_LATENCY=3
      base3 = 20'hFFFFE; num3 = 20'd4; start3 = 1;
      for (int c = 1; c <= 10; c++) begin
         step(); start3 = 0; settle(); cyc = c;
         chk("wrap_rd_en", if3.mem_rd_en, (c >= 1 && c <= 4));
         if (c >= 1 && c <= 4) chk("wrap_addr", if3.mem_addr, wrap_a[c-1]);
         chk("wrap_valid", if3.valid_weight_out, (c >= 5 && c <= 8));
         if (c >= 5 && c <= 8) chk("wrap_weight", if3.weight_out, wrap_a[c-5]);
         chk("wrap_done", done3, (c == 9));
         chk("wrap_busy", busy3, (c <= 9));
      end

      // Reset mid-block with two reads in flight
      base1 = 20'h80; num1 = 20'd8; start1 = 1;
      step(); start1 = 0;
      step(); settle(); cyc = 2;
      chk("midrst_rd_en_pre", if1.mem_rd_en, 1);
      chk("midrst_addr_pre", if1.mem_addr, 32'h81);
      reset = 1'b0;
      settle();
      chk_quiet1("midrst_now");
      for (int c = 3; c <= 5; c++) begin
         step(); cyc = c;
         chk_quiet1("midrst_hold");
      end
      chk_stream("midrst", 0);
      reset = 1'b1;
      step();
      base1 = 20'h20; num1 = 20'd2; start1 = 1;
      for (int c = 1; c <= 6; c++) begin
         step(); start1 = 0; settle(); cyc = c;
         chk("restart_rd_en", if1.mem_rd_en, (c <= 2));
         if (c <= 2) chk("restart_addr", if1.mem_addr, 32'h20 + c - 1);
         chk("restart_valid", if1.valid_weight_out, (c >= 3 && c <= 4));
         chk("restart_done", done1, (c == 5));
      end
      exp_q = '{32'h20, 32'h21};
      chk_stream("restart", 1);

      // Start while busy (during DRAIN) is ignored
      base1 = 20'h30; num1 = 20'd3; start1 = 1;
      for (int c = 1; c <= 10; c++) begin
         step(); start1 = (c == 4); base1 = 20'h99; num1 = 20'd5; settle(); cyc = c;
         if (c == 4) chk("busy_start_state", st1, ST_DRAIN);
         chk("busy_start_rd_en", if1.mem_rd_en, (c <= 3));
         chk("busy_start_valid", if1.valid_weight_out, (c >= 3 && c <= 5));
         chk("busy_start_done", done1, (c == 6));
         chk("busy_start_busy", busy1, (c <= 6));
      end
      start1 = 0;
      exp_q = '{32'h30, 32'h31, 32'h32};
      chk_stream("busy_start", 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
